// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: requester request/response ports plus the shared AXI AR/R channel
interface axi_rd_arbiter_if #(
  parameter int NUM_DECOMPRESSOR = 2,
  parameter int ADDR_W           = 64,
  parameter int DATA_W           = 512
);
  logic [NUM_DECOMPRESSOR-1:0]        req_valid;
  logic [NUM_DECOMPRESSOR*ADDR_W-1:0] req_addr;
  logic [NUM_DECOMPRESSOR*8-1:0]      req_len;
  logic [NUM_DECOMPRESSOR-1:0]        req_ready;
  logic                               m_arvalid;
  logic [ADDR_W-1:0]                  m_araddr;
  logic [7:0]                         m_arlen;
  logic                               m_arid;
  logic                               m_arready;
  logic                               m_rvalid;
  logic [DATA_W-1:0]                  m_rdata;
  logic                               m_rlast;
  logic                               m_rready;
  logic [NUM_DECOMPRESSOR-1:0]        rsp_valid;
  logic [DATA_W-1:0]                  rsp_data;
  logic                               rsp_last;
  logic [NUM_DECOMPRESSOR-1:0]        rsp_ready;
  logic [3:0]                         outstanding;
  modport master (
    input  req_valid, req_addr, req_len, m_arready, m_rvalid, m_rdata, m_rlast, rsp_ready,
    output req_ready, m_arvalid, m_araddr, m_arlen, m_arid, m_rready, rsp_valid, rsp_data,
           rsp_last, outstanding
  );
  modport slave (
    output req_valid, req_addr, req_len, m_arready, m_rvalid, m_rdata, m_rlast, rsp_ready,
    input  req_ready, m_arvalid, m_araddr, m_arlen, m_arid, m_rready, rsp_valid, rsp_data,
           rsp_last, outstanding
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin AR arbitration over N requesters with in-order R routing
module axi_rd_arbiter #(
  parameter int NUM_DECOMPRESSOR = 2,
  parameter int ADDR_W           = 64,
  parameter int DATA_W           = 512,
  parameter int DEPTH            = 8
) (
  input logic clk,
  input logic rst,
  axi_rd_arbiter_if.master bus
);
  localparam int N  = NUM_DECOMPRESSOR;
  localparam int IW = $clog2(N);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t            r_state;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     r_idx;
  logic [N-1:0]      r_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic              r_arvalid;
  logic [N-1:0]      r_fifo [DEPTH];
  logic [2:0]        r_wp;
  logic [2:0]        r_rp;
  logic [3:0]        r_cnt;
  logic              w_found;
  logic [IW-1:0]     w_idx;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [N-1:0]      w_sel;
  // first valid requester strictly after the last granted one, wrapping
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!w_found && bus.req_valid[IW'((int'(r_rr_ptr) + k) % N)]) begin
        w_found = 1'b1;
        w_idx   = IW'((int'(r_rr_ptr) + k) % N);
      end
    end
  end
  assign w_push  = r_arvalid & bus.m_arready;
  assign w_empty = (r_cnt == 4'd0);
  assign w_sel   = w_empty ? '0 : r_fifo[r_rp];
  assign w_pop   = bus.m_rvalid & bus.m_rready & bus.m_rlast;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= IW'(N - 1);
      r_idx     <= '0;
      r_gnt     <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_arvalid <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_found && r_cnt != 4'(DEPTH)) begin
        r_state   <= ISSUE;
        r_arvalid <= 1'b1;
        r_idx     <= w_idx;
        r_gnt     <= N'(1) << w_idx;
        r_addr    <= bus.req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
        r_len     <= bus.req_len[int'(w_idx)*8 +: 8];
      end
    end else if (bus.m_arready) begin
      r_state   <= IDLE;
      r_arvalid <= 1'b0;
      r_rr_ptr  <= r_idx;
    end
  end
  // order FIFO: one grant one-hot per issued burst, popped on each rlast beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_fifo[r_wp] <= r_gnt;
      r_wp  <= r_wp + 3'(w_push);
      r_rp  <= r_rp + 3'(w_pop);
      r_cnt <= r_cnt + 4'(w_push) - 4'(w_pop);
    end
  end
  assign bus.req_ready   = w_push ? r_gnt : '0;
  assign bus.m_arvalid   = r_arvalid;
  assign bus.m_araddr    = r_addr;
  assign bus.m_arlen     = r_len;
  assign bus.m_arid      = 1'b0;
  assign bus.m_rready    = |(w_sel & bus.rsp_ready);
  assign bus.rsp_valid   = w_sel & {N{bus.m_rvalid}};
  assign bus.rsp_data    = bus.m_rdata;
  assign bus.rsp_last    = bus.m_rlast;
  assign bus.outstanding = r_cnt;
endmodule
